// File: rtl/mem_bus_ctrl.sv
// Wait-state SRAM bus controller between the CPU control unit and an async SRAM.
// Optional MEM_BUS_MMIO_EN maps address 16'hFFFF to switches (read) / hex display (write).
module mem_bus_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_out,
  input  logic [15:0] SW,
  input  logic [15:0] Data_from_SRAM,
  output logic [15:0] Data_to_CPU,
  output logic        Rd_valid,
  output logic        Wr_done,
  output logic        Busy,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        CE_N,
  output logic        UB_N,
  output logic        LB_N,
  output logic        OE_N,
  output logic        WE_N,
  output logic [15:0] HEX_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        rd_valid_q;
  logic        wr_done_q;
  logic        busy_q;
  logic        ce_n_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic        mmio_hit;
  logic [15:0] mmio_rdata;

`ifdef MEM_BUS_MMIO_EN
  logic [15:0] hex_q;

  assign mmio_hit   = (MAR == 16'hFFFF);
  assign mmio_rdata = SW;
  assign HEX_data   = hex_q;
`else
  logic unused_sw;

  assign mmio_hit   = 1'b0;
  assign mmio_rdata = '0;
  assign HEX_data   = '0;
  assign unused_sw  = ^SW;
`endif

  // Strobes and pulses are registered alongside the state so they change on the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      busy_q     <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
`ifdef MEM_BUS_MMIO_EN
      hex_q      <= '0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Mem_WE) begin
            addr_q  <= MAR;
            wdata_q <= MDR_out;
            cnt_q   <= CNT_INIT;
            if (mmio_hit) begin
              state_q   <= DONE;
              wr_done_q <= 1'b1;
`ifdef MEM_BUS_MMIO_EN
              hex_q     <= MDR_out;
`endif
            end else begin
              state_q <= WRITE;
              busy_q  <= 1'b1;
              ce_n_q  <= 1'b0;
              we_n_q  <= 1'b0;
            end
          end else if (Mem_OE) begin
            addr_q <= MAR;
            cnt_q  <= CNT_INIT;
            if (mmio_hit) begin
              state_q    <= DONE;
              rd_valid_q <= 1'b1;
              rdata_q    <= mmio_rdata;
            end else begin
              state_q <= READ;
              busy_q  <= 1'b1;
              ce_n_q  <= 1'b0;
              oe_n_q  <= 1'b0;
            end
          end
        end
        READ: begin
          if (cnt_q == '0) begin
            rdata_q    <= Data_from_SRAM;
            rd_valid_q <= 1'b1;
            state_q    <= DONE;
            busy_q     <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WRITE: begin
          if (cnt_q == '0) begin
            wr_done_q <= 1'b1;
            state_q   <= DONE;
            busy_q    <= 1'b0;
            ce_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          // Wait for the request levels to drop so a held request is not re-issued.
          if (!Mem_OE && !Mem_WE) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Data_to_CPU  = rdata_q;
  assign Rd_valid     = rd_valid_q;
  assign Wr_done      = wr_done_q;
  assign Busy         = busy_q;
  assign ADDR         = {4'h0, addr_q};
  assign Data_to_SRAM = wdata_q;
  assign CE_N         = ce_n_q;
  assign UB_N         = ce_n_q;
  assign LB_N         = ce_n_q;
  assign OE_N         = oe_n_q;
  assign WE_N         = we_n_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl at WAIT_CYCLES = 1, 2 and 15 with a behavioural SRAM.
module tb_mem_bus_ctrl;

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] dout;
    logic [15:0] hex;
    int unsigned due;
    int unsigned strobes;
  } exp_t;

  logic        clk;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          blocks_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cfg=%0d actual=%h required=%h t=%0t", nm, g, act, req, $time);
    end
  endtask

  function automatic int unsigned sidx(logic [15:0] a);
    return (a == 16'hFFFF) ? 16 : int'(a[7:4]);
  endfunction

  function automatic logic [15:0] addr_of(int unsigned i);
    return (i >= 16) ? 16'hFFFF : 16'(i << 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int unsigned W = (g == 0) ? 1 : (g == 1) ? 2 : 15;

    logic        rst, oe, we;
    logic [15:0] mar, mdr, sw, din;
    logic [15:0] dout, d2s, hex;
    logic        rdv, wrd, busy, ce_n, ub_n, lb_n, oe_n, we_n;
    logic [19:0] addr;

    mem_bus_ctrl #(.WAIT_CYCLES(W)) u_dut (
      .Clk(clk), .Reset(rst), .Mem_OE(oe), .Mem_WE(we), .MAR(mar), .MDR_out(mdr),
      .SW(sw), .Data_from_SRAM(din), .Data_to_CPU(dout), .Rd_valid(rdv),
      .Wr_done(wrd), .Busy(busy), .ADDR(addr), .Data_to_SRAM(d2s), .CE_N(ce_n),
      .UB_N(ub_n), .LB_N(lb_n), .OE_N(oe_n), .WE_N(we_n), .HEX_data(hex)
    );

    // Behavioural SRAM: drives garbage unless the chip is actually being read.
    logic [15:0] sram [17];
    always_comb din = (!ce_n && !oe_n) ? sram[sidx(addr[15:0])] : 16'hDEAD;
    always @(posedge clk) if (!ce_n && !we_n) sram[sidx(addr[15:0])] <= d2s;

    exp_t        q[$];
    int unsigned completions = 0;
    int unsigned oe_low = 0;
    int unsigned we_low = 0;
    logic [15:0] ref_mem [17];
    logic [15:0] last_rd;
    logic [15:0] hex_m;

    always @(posedge clk) begin
      exp_t e;
      #1;
      chk("oe_we_exclusive", g, 32'(oe_n | we_n), 32'd1);
      chk("busy_vs_strobe", g, 32'(busy), 32'(!ce_n));
      chk("ub_lb_follow_ce", g, {30'd0, ub_n, lb_n}, {30'd0, ce_n, ce_n});
      chk("pulse_exclusive", g, 32'(rdv & wrd), 32'd0);
      if (!oe_n) oe_low++;
      if (!we_n) we_low++;
      if (rst) begin
        oe_low = 0;
        we_low = 0;
      end
      if (rdv || wrd) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", g, {30'd0, rdv, wrd}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", g, 32'(wrd), 32'(e.is_wr));
          chk("latency_cycle", g, cyc, e.due);
          chk("oe_low_cycles", g, oe_low, e.is_wr ? 0 : e.strobes);
          chk("we_low_cycles", g, we_low, e.is_wr ? e.strobes : 0);
          chk("addr_latched", g, 32'(addr), {12'd0, 4'h0, e.addr});
          chk("data_to_cpu", g, 32'(dout), 32'(e.dout));
          chk("hex_data", g, 32'(hex), 32'(e.hex));
          if (e.is_wr) chk("data_to_sram", g, 32'(d2s), 32'(e.wdata));
        end
        completions++;
        oe_low = 0;
        we_low = 0;
      end
    end

    task automatic check_reset_state();
      chk("rst_data_to_cpu", g, 32'(dout), 32'd0);
      chk("rst_strobes", g, {27'd0, ce_n, ub_n, lb_n, oe_n, we_n}, 32'h1F);
      chk("rst_busy_pulses", g, {29'd0, busy, rdv, wrd}, 32'd0);
      chk("rst_addr", g, 32'(addr), 32'd0);
      chk("rst_data_to_sram", g, 32'(d2s), 32'd0);
      chk("rst_hex", g, 32'(hex), 32'd0);
    endtask

    // kind: 0 read, 1 write, 2 read+write together (write must win)
    task automatic do_txn(int kind, logic [15:0] a, logic [15:0] d, bit abort);
      exp_t        e;
      int unsigned c, start;
      bit          mmio;
      @(negedge clk);
      mmio = 1'b0;
`ifdef MEM_BUS_MMIO_EN
      mmio = (a == 16'hFFFF);
`endif
      sw  = 16'($urandom);
      mar = a;
      mdr = d;
      oe  = (kind != 1);
      we  = (kind != 0);
      c   = cyc;
      if (abort) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state();
        rst     = 1'b0;
        last_rd = '0;
        hex_m   = '0;
        c       = cyc;
      end
      e.is_wr   = (kind != 0);
      e.addr    = a;
      e.strobes = mmio ? 0 : W;
      e.due     = c + 1 + e.strobes;
      e.wdata   = d;
      if (e.is_wr) begin
        if (mmio) hex_m = d;
        else ref_mem[sidx(a)] = d;
      end else begin
        last_rd = mmio ? sw : ref_mem[sidx(a)];
      end
      e.dout = last_rd;
      e.hex  = hex_m;
      start  = completions;
      q.push_back(e);
      @(negedge clk);
      mar = 16'($urandom);
      mdr = 16'($urandom);
      for (int k = 0; k < int'(W) + 6 && completions == start; k++) @(negedge clk);
      chk("completion_count", g, completions - start, 32'd1);
      if (completions != start + 1) q.delete();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      oe = 1'b0;
      we = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    endtask

    initial begin
      int unsigned kind, ai;
      rst = 1'b1; oe = 1'b0; we = 1'b0;
      mar = '0; mdr = '0; sw = '0;
      last_rd = '0;
      hex_m = '0;
      repeat (3) @(negedge clk);
      check_reset_state();
      rst = 1'b0;
      for (int unsigned i = 0; i < 17; i++) do_txn(1, addr_of(i), 16'($urandom), 1'b0);
      do_txn(1, 16'h0020, 16'hBEEF, 1'b0);
      do_txn(0, 16'h0020, 16'h0000, 1'b0);
      do_txn(2, 16'h0010, 16'h1234, 1'b0);
      do_txn(0, 16'h0010, 16'h0000, 1'b0);
      for (int unsigned i = 0; i < 24; i++) begin
        kind = $urandom_range(0, 2);
        ai   = $urandom_range(0, 16);
        if (i % 8 == 5) do_txn(0, addr_of(i % 16), 16'h0, 1'b1);
        else do_txn(int'(kind), addr_of(ai), 16'($urandom), 1'b0);
      end
      blocks_done++;
    end
  end

  initial begin
    for (int i = 0; i < 60000 && blocks_done < 3; i++) @(posedge clk);
    chk("all_configs_done", -1, 32'(blocks_done), 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
